flush_sequencer: RTL and testbench



---
 rtl/flush_sequencer.sv | 155 +++++++++++++++
 tb/tb_flush_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flush_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// flush_sequencer
//
// Steps through the multi-stage flushes that the commit stage requests:
// FENCE, FENCE.I, FENCE.T, SFENCE.VMA, AMO pipeline flush and exception
// redirect. While a sequence is in flight the commit stage is halted. Every
// sequence ends with a one-cycle pipeline flush plus PC redirect, after which
// the FSM returns to IDLE.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   ex_valid_i           exception taken at commit (pulse)
//   fence_i              FENCE committed (pulse)
//   fence_i_i            FENCE.I committed (pulse)
//   fence_t_i            FENCE.T committed (pulse)
//   sfence_vma_i         SFENCE.VMA committed (pulse)
//   flush_commit_i       AMO flush request (pulse)
//   flush_dcache_ack_i   D$ flush complete
//   flush_dcache_o       D$ flush request (level, held until ack)
//   flush_icache_o       I$ flush (one-cycle pulse)
//   flush_tlb_o          TLB flush (one-cycle pulse)
//   flush_pipe_o         IF/ID/EX flush (one-cycle pulse)
//   set_pc_commit_o      frontend redirect (one-cycle pulse)
//   halt_o, busy_o       high whenever the FSM is not IDLE
//   flush_cycles_o       busy-cycle counter
//
// Handshake: requests are single-cycle pulses and are only accepted in IDLE;
// anything arriving while busy is dropped. flush_dcache_o is a level request
// that stays high until flush_dcache_ack_i is sampled high on a clock edge.
//
// Optional feature macro FLUSH_SEQUENCER_PERF_EN: when defined,
// flush_cycles_o is a saturating 32-bit count of busy cycles since reset;
// when undefined it is tied to zero and no counter flops exist.
//
// All outputs are decoded from the registered state only (Moore).
// -----------------------------------------------------------------------------
module flush_sequencer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    input  logic        fence_i,
    input  logic        fence_i_i,
    input  logic        fence_t_i,
    input  logic        sfence_vma_i,
    input  logic        flush_commit_i,
    input  logic        flush_dcache_ack_i,
    output logic        flush_dcache_o,
    output logic        flush_icache_o,
    output logic        flush_tlb_o,
    output logic        flush_pipe_o,
    output logic        set_pc_commit_o,
    output logic        halt_o,
    output logic        busy_o,
    output logic [31:0] flush_cycles_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DCACHE = 3'd1;
    localparam logic [2:0] ST_ICACHE = 3'd2;
    localparam logic [2:0] ST_TLB    = 3'd3;
    localparam logic [2:0] ST_PIPE   = 3'd4;

    // Stored request type; only consulted in DCACHE and ICACHE to pick the
    // next step, so requests that never visit those states store REQ_NONE.
    localparam logic [1:0] REQ_FENCE   = 2'd0;
    localparam logic [1:0] REQ_FENCE_I = 2'd1;
    localparam logic [1:0] REQ_FENCE_T = 2'd2;
    localparam logic [1:0] REQ_NONE    = 2'd3;

    logic [2:0] state_q, state_d;
    logic [1:0] req_q, req_d;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                // Fixed priority; lower-priority simultaneous requests are dropped.
                if (ex_valid_i) begin
                    state_d = ST_PIPE;
                    req_d   = REQ_NONE;
                end else if (fence_t_i) begin
                    state_d = ST_DCACHE;
                    req_d   = REQ_FENCE_T;
                end else if (fence_i_i) begin
                    state_d = ST_DCACHE;
                    req_d   = REQ_FENCE_I;
                end else if (fence_i) begin
                    state_d = ST_DCACHE;
                    req_d   = REQ_FENCE;
                end else if (sfence_vma_i) begin
                    state_d = ST_TLB;
                    req_d   = REQ_NONE;
                end else if (flush_commit_i) begin
                    state_d = ST_PIPE;
                    req_d   = REQ_NONE;
                end
            end
            ST_DCACHE: begin
                if (flush_dcache_ack_i) begin
                    state_d = (req_q == REQ_FENCE) ? ST_PIPE : ST_ICACHE;
                end
            end
            ST_ICACHE: begin
                state_d = (req_q == REQ_FENCE_T) ? ST_TLB : ST_PIPE;
            end
            ST_TLB: begin
                state_d = ST_PIPE;
            end
            ST_PIPE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            req_q   <= REQ_NONE;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    assign flush_dcache_o  = (state_q == ST_DCACHE);
    assign flush_icache_o  = (state_q == ST_ICACHE);
    assign flush_tlb_o     = (state_q == ST_TLB);
    assign flush_pipe_o    = (state_q == ST_PIPE);
    assign set_pc_commit_o = (state_q == ST_PIPE);
    assign busy_o          = (state_q != ST_IDLE);
    assign halt_o          = (state_q != ST_IDLE);

`ifdef FLUSH_SEQUENCER_PERF_EN
    logic [31:0] cycles_q;

    // Saturating; never cleared except by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycles_q <= 32'd0;
        end else if ((state_q != ST_IDLE) && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign flush_cycles_o = cycles_q;
`else
    assign flush_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_flush_sequencer.sv
`timescale 1ns/1ps
module tb_flush_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic        ex_valid_i = 1'b0;
    logic        fence_i = 1'b0;
    logic        fence_i_i = 1'b0;
    logic        fence_t_i = 1'b0;
    logic        sfence_vma_i = 1'b0;
    logic        flush_commit_i = 1'b0;
    logic        flush_dcache_ack_i = 1'b0;
    logic        flush_dcache_o;
    logic        flush_icache_o;
    logic        flush_tlb_o;
    logic        flush_pipe_o;
    logic        set_pc_commit_o;
    logic        halt_o;
    logic        busy_o;
    logic [31:0] flush_cycles_o;

    flush_sequencer dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .ex_valid_i         (ex_valid_i),
        .fence_i            (fence_i),
        .fence_i_i          (fence_i_i),
        .fence_t_i          (fence_t_i),
        .sfence_vma_i       (sfence_vma_i),
        .flush_commit_i     (flush_commit_i),
        .flush_dcache_ack_i (flush_dcache_ack_i),
        .flush_dcache_o     (flush_dcache_o),
        .flush_icache_o     (flush_icache_o),
        .flush_tlb_o        (flush_tlb_o),
        .flush_pipe_o       (flush_pipe_o),
        .set_pc_commit_o    (set_pc_commit_o),
        .halt_o             (halt_o),
        .busy_o             (busy_o),
        .flush_cycles_o     (flush_cycles_o)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A request turns into a list of steps: D (D$ flush, waits for ack),
    // I (I$), T (TLB), P (pipe flush + redirect). The head of the list is
    // what the outputs show in the current cycle; an empty list is idle.
    string       plan = "";
    logic [31:0] m_cnt = 32'd0;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            plan = "";
            m_cnt = 32'd0;
        end else if (plan.len() != 0) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (plan[0] != "D" || flush_dcache_ack_i)
                plan = plan.substr(1, plan.len() - 1);
        end else begin
            if (ex_valid_i)          plan = "P";
            else if (fence_t_i)      plan = "DITP";
            else if (fence_i_i)      plan = "DIP";
            else if (fence_i)        plan = "DP";
            else if (sfence_vma_i)   plan = "TP";
            else if (flush_commit_i) plan = "P";
        end
    end

    // ---------------- scoreboard: compare every cycle ----------------
    logic [31:0] exp_cnt;
    always @(negedge clk) begin
        logic e_busy, e_dc, e_ic, e_tlb, e_pipe;
        e_busy = (plan.len() != 0);
        e_dc   = e_busy && (plan[0] == "D");
        e_ic   = e_busy && (plan[0] == "I");
        e_tlb  = e_busy && (plan[0] == "T");
        e_pipe = e_busy && (plan[0] == "P");
`ifdef FLUSH_SEQUENCER_PERF_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 32'd0;
`endif
        check("flush_dcache_o", {31'd0, flush_dcache_o}, {31'd0, e_dc});
        check("flush_icache_o", {31'd0, flush_icache_o}, {31'd0, e_ic});
        check("flush_tlb_o", {31'd0, flush_tlb_o}, {31'd0, e_tlb});
        check("flush_pipe_o", {31'd0, flush_pipe_o}, {31'd0, e_pipe});
        check("set_pc_commit_o", {31'd0, set_pc_commit_o}, {31'd0, e_pipe});
        check("halt_o", {31'd0, halt_o}, {31'd0, e_busy});
        check("busy_o", {31'd0, busy_o}, {31'd0, e_busy});
        check("flush_cycles_o", flush_cycles_o, exp_cnt);
    end

    // ---------------- driver tasks ----------------
    // Request vector bits: 5 ex, 4 fence_t, 3 fence_i_i, 2 fence, 1 sfence, 0 amo
    task automatic drive_req(input logic [5:0] r);
        ex_valid_i     = r[5];
        fence_t_i      = r[4];
        fence_i_i      = r[3];
        fence_i        = r[2];
        sfence_vma_i   = r[1];
        flush_commit_i = r[0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_req(6'd0);
        flush_dcache_ack_i = 1'b0;
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Observation results from run_seq (cycle indices are relative to the
    // request cycle; 0 means never seen).
    int n_dc, n_ic, n_tlb, n_pipe, n_pc, n_busy;
    int f_dc, f_ic, f_tlb, f_pipe;

    // Drives req0 for one cycle, req1 in the following cycle, answers the D$
    // request ack_delay cycles after it rises, and counts outputs.
    task automatic run_seq(input logic [5:0] req0, input logic [5:0] req1,
                           input int ack_delay, input bit stray_ack, input int ncyc);
        n_dc = 0; n_ic = 0; n_tlb = 0; n_pipe = 0; n_pc = 0; n_busy = 0;
        f_dc = 0; f_ic = 0; f_tlb = 0; f_pipe = 0;
        @(negedge clk);
        drive_req(req0);
        flush_dcache_ack_i = stray_ack;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            drive_req((c == 1) ? req1 : 6'd0);
            if (flush_dcache_o) begin n_dc++; if (f_dc == 0) f_dc = c; end
            if (flush_icache_o) begin n_ic++; if (f_ic == 0) f_ic = c; end
            if (flush_tlb_o) begin n_tlb++; if (f_tlb == 0) f_tlb = c; end
            if (flush_pipe_o) begin n_pipe++; if (f_pipe == 0) f_pipe = c; end
            if (set_pc_commit_o) n_pc++;
            if (halt_o) n_busy++;
            if (stray_ack && c < 2) flush_dcache_ack_i = 1'b1;
            else flush_dcache_ack_i = flush_dcache_o && (n_dc >= ack_delay + 1);
        end
        drive_req(6'd0);
        flush_dcache_ack_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset held 3 cycles with a FENCE pending on the input.
        rst_ni = 1'b0;
        fence_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs",
                  {25'd0, flush_dcache_o, flush_icache_o, flush_tlb_o, flush_pipe_o,
                   set_pc_commit_o, halt_o, busy_o}, 32'd0);
            check("reset_cycles", flush_cycles_o, 32'd0);
        end
        fence_i = 1'b0;
        rst_ni = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_after_reset", {31'd0, busy_o}, 32'd0);
        end

        // FENCE, ack 4 cycles after flush_dcache_o rises.
        do_reset();
        run_seq(6'b000100, 6'd0, 4, 1'b0, 8);
        check("fence_dc_cycles", n_dc, 5);
        check("fence_pipe_cycles", n_pipe, 1);
        check("fence_pc_cycles", n_pc, 1);
        check("fence_pipe_at", f_pipe, 6);
        check("fence_halt_cycles", n_busy, 6);

        // FENCE.T with immediate ack.
        do_reset();
        run_seq(6'b010000, 6'd0, 0, 1'b0, 6);
        check("fencet_dc_at", f_dc, 1);
        check("fencet_ic_at", f_ic, 2);
        check("fencet_tlb_at", f_tlb, 3);
        check("fencet_pipe_at", f_pipe, 4);
        check("fencet_each_once", n_dc + n_ic + n_tlb + n_pipe, 4);
        check("fencet_busy_cycles", n_busy, 4);

        // FENCE.I with 2-cycle ack delay: D$ time 3, pipe at 3 + 2.
        do_reset();
        run_seq(6'b001000, 6'd0, 2, 1'b0, 7);
        check("fencei_pipe_at", f_pipe, 5);
        check("fencei_tlb_cycles", n_tlb, 0);

        // Exception together with FENCE.I: pipe only.
        do_reset();
        run_seq(6'b101000, 6'd0, 0, 1'b0, 4);
        check("ex_prio_dc_cycles", n_dc, 0);
        check("ex_prio_pipe_at", f_pipe, 1);
        check("ex_prio_busy", n_busy, 1);

        // Stray ack in IDLE.
        run_seq(6'd0, 6'd0, 0, 1'b1, 3);
        check("stray_ack_busy", n_busy, 0);

        // SFENCE.VMA, then FENCE pulsed while busy.
        do_reset();
        run_seq(6'b000010, 6'b000100, 0, 1'b0, 5);
        check("sfence_tlb_at", f_tlb, 1);
        check("sfence_pipe_at", f_pipe, 2);
        check("sfence_busy", n_busy, 2);
        check("sfence_dc_cycles", n_dc, 0);

        // FENCE with 3-cycle ack delay followed by an exception.
        do_reset();
        run_seq(6'b000100, 6'd0, 3, 1'b0, 6);
        run_seq(6'b100000, 6'd0, 0, 1'b0, 3);
`ifdef FLUSH_SEQUENCER_PERF_EN
        check("perf_cycles", flush_cycles_o, 32'd6);
`else
        check("perf_cycles", flush_cycles_o, 32'd0);
`endif

        // Randomized traffic with occasional asynchronous reset mid-sequence.
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) drive_req(6'($urandom_range(1, 63)));
            else drive_req(6'd0);
            flush_dcache_ack_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_ni = 1'b0;
                #1 check("async_reset_busy", {31'd0, busy_o}, 32'd0);
                #1 rst_ni = 1'b1;
            end
        end
        drive_req(6'd0);
        flush_dcache_ack_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
